// File: rtl/diablo_pkg.sv
// Shared types and widths for the decode/execute boundary of the diablo core.
package diablo_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01
    } alu_op_t;

    // op stays a raw 2-bit field so undefined encodings travel through untouched.
    typedef struct packed {
        logic [XLEN-1:0]      in1;
        logic [XLEN-1:0]      in2;
        logic [1:0]           op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1_idx;
        logic [REG_IDX_W-1:0] rs2_idx;
        logic                 use_imm;
    } ex_entry_t;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Combinational operand override for one ID/EX entry from the write-back bus.
// Active only when ID_EX_FWD_EN is defined; otherwise the entry passes through.
module id_ex_fwd_mux
    import diablo_pkg::*;
(
    input  ex_entry_t            entry,
    input  logic                 fwd_valid,
    input  logic [REG_IDX_W-1:0] fwd_rd_idx,
    input  logic [XLEN-1:0]      fwd_data,
    output ex_entry_t            fwd_entry
);

`ifdef ID_EX_FWD_EN
    logic hit;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    always_comb begin
        fwd_entry = entry;
        hit       = fwd_valid && (fwd_rd_idx != '0);
        if (hit && (fwd_rd_idx == entry.rs1_idx))
            fwd_entry.in1 = fwd_data;
        if (hit && !entry.use_imm && (fwd_rd_idx == entry.rs2_idx))
            fwd_entry.in2 = fwd_data;
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{fwd_valid, fwd_rd_idx, fwd_data};
    assign fwd_entry  = entry;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a 2-entry skid buffer feeding the 64-bit ALU.
// Define ID_EX_FWD_EN to enable capture-time and stall-time register forwarding.
module id_ex_stage
    import diablo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_rs1_val,
    input  logic [XLEN-1:0]      in_rs2_val,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_use_imm,
    input  logic [1:0]           in_op,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic                 in_flush,
    input  logic                 fwd_valid,
    input  logic [REG_IDX_W-1:0] fwd_rd_idx,
    input  logic [XLEN-1:0]      fwd_data,
    output logic [XLEN-1:0]      alu_in1,
    output logic [XLEN-1:0]      alu_in2,
    output logic [1:0]           alu_signal,
    output logic [REG_IDX_W-1:0] out_rd_idx,
    output logic                 out_valid,
    input  logic                 out_ready
);

    ex_entry_t cap_p0, cap_fwd_p0;
    ex_entry_t main_p1, main_fwd, main_nxt;
    ex_entry_t skid_p1, skid_fwd, skid_nxt;
    logic      vld_p1, skid_vld_p1, rdy_p1;
    logic      vld_nxt, skid_vld_nxt;
    logic      accept, xfer;

    assign accept = in_valid & rdy_p1;
    assign xfer   = vld_p1 & out_ready;

    always_comb begin
        cap_p0         = '0;
        cap_p0.in1     = in_rs1_val;
        cap_p0.in2     = in_use_imm ? in_imm : in_rs2_val;
        cap_p0.op      = in_op;
        cap_p0.rd      = in_rd_idx;
        cap_p0.rs1_idx = in_rs1_idx;
        cap_p0.rs2_idx = in_rs2_idx;
        cap_p0.use_imm = in_use_imm;
    end

    id_ex_fwd_mux u_fwd_cap (
        .entry(cap_p0), .fwd_valid(fwd_valid), .fwd_rd_idx(fwd_rd_idx),
        .fwd_data(fwd_data), .fwd_entry(cap_fwd_p0)
    );

    id_ex_fwd_mux u_fwd_main (
        .entry(main_p1), .fwd_valid(fwd_valid), .fwd_rd_idx(fwd_rd_idx),
        .fwd_data(fwd_data), .fwd_entry(main_fwd)
    );

    id_ex_fwd_mux u_fwd_skid (
        .entry(skid_p1), .fwd_valid(fwd_valid), .fwd_rd_idx(fwd_rd_idx),
        .fwd_data(fwd_data), .fwd_entry(skid_fwd)
    );

    // Held entries always reload through their forward mux so stalls pick up write-backs.
    always_comb begin
        main_nxt     = main_fwd;
        skid_nxt     = skid_fwd;
        vld_nxt      = vld_p1;
        skid_vld_nxt = skid_vld_p1;
        if (!vld_p1) begin
            if (accept) begin
                main_nxt = cap_fwd_p0;
                vld_nxt  = 1'b1;
            end
        end else if (!skid_vld_p1) begin
            if (xfer && accept) begin
                main_nxt = cap_fwd_p0;
            end else if (xfer) begin
                vld_nxt = 1'b0;
            end else if (accept) begin
                skid_nxt     = cap_fwd_p0;
                skid_vld_nxt = 1'b1;
            end
        end else if (xfer) begin
            main_nxt     = skid_fwd;
            skid_vld_nxt = 1'b0;
        end
        if (in_flush) begin
            vld_nxt      = 1'b0;
            skid_vld_nxt = 1'b0;
        end
    end

    // p0 -> p1: control and output-facing entry
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            main_p1     <= '0;
        end else begin
            vld_p1      <= vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            rdy_p1      <= ~skid_vld_nxt;
            main_p1     <= main_nxt;
        end
    end

    always_ff @(posedge clk) begin
        skid_p1 <= skid_nxt;
    end

    assign in_ready   = rdy_p1;
    assign out_valid  = vld_p1;
    assign alu_in1    = main_p1.in1;
    assign alu_in2    = main_p1.in2;
    assign alu_signal = main_p1.op;
    assign out_rd_idx = main_p1.rd;

endmodule
